// File: rtl/dmem_responder.sv
// Single-port 128-bit line memory behind a cyc/stb request bus.
// Each accepted request is answered after LATENCY edges with a one-cycle dmem_resp.
module dmem_responder #(
  parameter int LATENCY = 2,
  parameter int LINES   = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         dmem_action_cyc,
  input  logic         dmem_action_stb,
  input  logic         dmem_write,
  input  logic [15:0]  dmem_address,
  input  logic [127:0] dmem_wdata,
  input  logic [15:0]  dmem_byte_enable,
  output logic [127:0] dmem_rdata,
  output logic         dmem_resp
);

  localparam int         IDX_W    = (LINES > 1) ? $clog2(LINES) : 1;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY    = 2'd1;
  localparam logic [1:0] ST_ACK     = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [3:0]       cnt_r;
  logic             wr_r;
  logic [IDX_W-1:0] idx_r;
  logic [127:0]     wdata_r;
  logic [15:0]      be_r;
  logic [127:0]     storage_r [LINES];
  logic [127:0]     rdata_r;
  logic             resp_r;
  logic             accept_s;
  logic             access_s;
  logic [127:0]     line_s;
  logic [127:0]     merged_s;
  logic             unused_addr_s;

  // Byte-masked merge of new write data into an existing line.
  function automatic logic [127:0] merge_bytes(input logic [127:0] old_line,
                                               input logic [127:0] new_data,
                                               input logic [15:0]  be);
    logic [127:0] res;
    res = old_line;
    for (int i = 0; i < 16; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_data[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_line[8*i +: 8];
      end
    end
    return res;
  endfunction

  assign unused_addr_s = ^{dmem_address[15:4+IDX_W], dmem_address[3:0]};
  assign accept_s      = (state_r == ST_IDLE) && dmem_action_cyc && dmem_action_stb;
  assign line_s        = storage_r[idx_r];
  assign merged_s      = merge_bytes(line_s, wdata_r, be_r);

  // Next-state logic; access_s marks the edge that enters ACK and commits the access.
  always_comb begin
    state_nxt_s = state_r;
    access_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (dmem_action_cyc && dmem_action_stb) begin
          state_nxt_s = ST_BUSY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // Dropping cyc abandons the request before anything is committed.
        if (!dmem_action_cyc) begin
          state_nxt_s = ST_IDLE;
        end else if (cnt_r == 4'd0) begin
          state_nxt_s = ST_ACK;
          access_s    = 1'b1;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      ST_ACK: begin
        if (dmem_action_stb) begin
          state_nxt_s = ST_RELEASE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RELEASE: begin
        if (!dmem_action_stb || !dmem_action_cyc) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RELEASE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, latency counter, request capture and registered response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      wr_r    <= 1'b0;
      idx_r   <= '0;
      wdata_r <= 128'd0;
      be_r    <= 16'd0;
      rdata_r <= 128'd0;
      resp_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      resp_r  <= access_s;
      if (accept_s) begin
        cnt_r   <= CNT_LOAD;
        wr_r    <= dmem_write;
        idx_r   <= dmem_address[4 +: IDX_W];
        wdata_r <= dmem_wdata;
        be_r    <= dmem_byte_enable;
      end else if ((state_r == ST_BUSY) && (cnt_r != 4'd0)) begin
        cnt_r <= cnt_r - 4'd1;
      end
      if (access_s) begin
        rdata_r <= wr_r ? merged_s : line_s;
      end
    end
  end

  // Line storage; written only on the edge that commits a write access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LINES; i++) begin
        storage_r[i] <= 128'd0;
      end
    end else begin
      if (access_s && wr_r) begin
        storage_r[idx_r] <= merged_s;
      end
    end
  end

  assign dmem_rdata = rdata_r;
  assign dmem_resp  = resp_r;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 2: the number of clock edges from request acceptance to the response edge (legal range 1..15).
REQ-002 SHALL have parameter LINES, default 32: the number of 128-bit storage lines (power of two, 2..256).
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port: clk  input  1  rising-edge clock.
REQ-005 SHALL have port: reset_n  input  1  async active-low reset.
REQ-006 SHALL have port: dmem_action_cyc  input  1  bus cycle active.
REQ-007 SHALL have port: dmem_action_stb  input  1  request strobe.
REQ-008 SHALL have port: dmem_write  input  1  1=write, 0=read.
REQ-009 SHALL have port: dmem_address  input  16  byte address; line index = address[4+log2(LINES)-1:4], other bits ignored.
REQ-010 SHALL have port: dmem_wdata  input  128  write line data.
REQ-011 SHALL have port: dmem_byte_enable  input  16  per-byte write mask; bit i covers wdata[8i+7:8i].
REQ-012 SHALL have port: dmem_rdata  output  128  registered line data.
REQ-013 SHALL have port: dmem_resp  output  1  one-cycle acknowledge.

Function
REQ-014 SHALL implement a FSM with states IDLE, BUSY, ACK and RELEASE.
REQ-015 IDLE SHALL accept a request on an edge where cyc=1 and stb=1, capture address, write, wdata and byte_enable, load the latency counter with LATENCY-1, and go to BUSY.
REQ-016 Captured fields SHALL be the only ones used; input changes after acceptance SHALL be ignored.
REQ-017 BUSY SHALL decrement the counter each edge and go to ACK on the edge where the counter equals 0.
REQ-018 dmem_resp SHALL be 1 exactly in ACK, i.e. for the single cycle following edge (accept edge + LATENCY).
REQ-019 Read: on the edge entering ACK, dmem_rdata SHALL load storage[index].
REQ-020 Write: on the edge entering ACK, storage[index] byte i SHALL take wdata byte i where byte_enable[i]=1; other bytes SHALL be unchanged.
REQ-021 Write: dmem_rdata SHALL load the merged post-write line on that same edge.
REQ-022 byte_enable=0 on a write SHALL produce an ack with no storage change.
REQ-023 dmem_rdata SHALL hold its value between responses.
REQ-024 ACK SHALL go to RELEASE if stb=1, else to IDLE.
REQ-025 RELEASE SHALL wait for stb=0 (or cyc=0) and then return to IDLE, so that one strobe is never serviced twice.
REQ-026 In BUSY, if cyc=0 is sampled, the FSM SHALL abort to IDLE with no storage write and no dmem_resp.
REQ-027 In ACK, cyc=0 SHALL NOT cancel the write already committed.
REQ-028 stb=1 with cyc=0 in IDLE SHALL be ignored.
REQ-029 Back-to-back requests SHALL be separated by at least one IDLE or RELEASE cycle; throughput SHALL be at most one access per LATENCY+2 cycles.

Reset
REQ-030 reset_n=0 SHALL asynchronously force state=IDLE, counter=0, dmem_resp=0, dmem_rdata=0 and all storage lines=0.
REQ-031 Reset asserted mid-transaction SHALL discard the transaction with no write and no ack; the first request after reset_n rises SHALL be serviced normally.

Verification
REQ-032 Write then read, LATENCY=2: write addr 0x0010, be=0xFFFF, wdata=0x00112233_44556677_8899AABB_CCDDEEFF, accept at edge E0 -> resp high only after E2; then read addr 0x0010 -> dmem_rdata=same value, resp after the read's accept edge + 2.
REQ-033 Partial write: line 0 is 0; write addr 0x0000, be=0x0003, wdata=all 0xFF bytes; then read -> dmem_rdata=0x...0000FFFF (only low 2 bytes set).
REQ-034 Held strobe: master keeps stb=1 for 3 cycles after resp -> exactly one resp pulse; storage written once.
REQ-035 Abort: drop cyc during BUSY on a write to 0x0020 -> no resp; a later read of 0x0020 returns 0.
REQ-036 Reset mid-op: assert reset_n=0 one cycle after accepting a write -> dmem_resp=0 and dmem_rdata=0 immediately; after release, a read of that line returns 0.
REQ-037 Address aliasing, LINES=32: write 0xA5 bytes to 0x0200 with be=0xFFFF, then read 0x0000 -> the same line is returned (index wraps).
